// File: rtl/button_debouncer_array.sv
// N-channel button debouncer: 2-flop synchroniser, shared 1 ms timebase, per-channel filter with press/release pulses.
// Define DEBOUNCER_AUTOREPEAT_EN to add auto-repeat pulses while a button is held.
module button_debouncer_array #(
  parameter int NUM_CH          = 5,
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] button_in,
  output logic [NUM_CH-1:0] button_level,
  output logic [NUM_CH-1:0] button_press,
  output logic [NUM_CH-1:0] button_release,
  output logic [NUM_CH-1:0] button_repeat,
  output logic              any_press
);

  localparam int DIV   = ((CLK_FREQ_HZ / 1000) > 1) ? (CLK_FREQ_HZ / 1000) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [NUM_CH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

  logic [DIV_W-1:0]  r_div_cnt;
  logic              w_ms_tick;
  logic [NUM_CH-1:0] r_sync0;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] w_s;

  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_level;
  logic [NUM_CH-1:0] w_level_nxt;
  logic [NUM_CH-1:0] r_press;
  logic [NUM_CH-1:0] w_press_nxt;
  logic [NUM_CH-1:0] r_release;
  logic [NUM_CH-1:0] w_release_nxt;
  logic              r_any_press;

  assign w_ms_tick = (r_div_cnt == DIV_LAST);

  // Shared millisecond prescaler
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (w_ms_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Synchroniser resets to the idle pin level so reset release never looks like a press
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync0 <= INACTIVE;
      r_sync1 <= INACTIVE;
    end else begin
      r_sync0 <= button_in;
      r_sync1 <= r_sync0;
    end
  end

  assign w_s = r_sync1 ^ INACTIVE;

  // Filter: any cycle matching the stable level restarts the count; the last tick commits the change
  always_comb begin
    w_level_nxt   = r_level;
    w_press_nxt   = {NUM_CH{1'b0}};
    w_release_nxt = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_s[i] == r_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_ms_tick) begin
        if (r_cnt[i] == DEB_LAST) begin
          w_cnt_nxt[i]     = '0;
          w_level_nxt[i]   = w_s[i];
          w_press_nxt[i]   = w_s[i];
          w_release_nxt[i] = ~w_s[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_level     <= {NUM_CH{1'b0}};
      r_press     <= {NUM_CH{1'b0}};
      r_release   <= {NUM_CH{1'b0}};
      r_any_press <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_any_press <= |w_press_nxt;
    end
  end

  assign button_level   = r_level;
  assign button_press   = r_press;
  assign button_release = r_release;
  assign any_press      = r_any_press;

`ifdef DEBOUNCER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_MS - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_MS - 1);

  logic [REP_W-1:0]  r_rep_cnt [NUM_CH];
  logic [REP_W-1:0]  w_rep_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_rep_next;
  logic [NUM_CH-1:0] w_rep_next_nxt;
  logic [NUM_CH-1:0] r_repeat;
  logic [NUM_CH-1:0] w_repeat_nxt;

  // Repeat timer: long first delay, then the faster rate; idle whenever the button is not held
  always_comb begin
    w_rep_next_nxt = r_rep_next;
    w_repeat_nxt   = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_rep_cnt_nxt[i] = r_rep_cnt[i];
      if (w_press_nxt[i]) begin
        w_rep_cnt_nxt[i]  = '0;
        w_rep_next_nxt[i] = 1'b0;
      end else if (r_level[i] && !w_release_nxt[i]) begin
        if (w_ms_tick) begin
          if (r_rep_cnt[i] == (r_rep_next[i] ? RATE_LAST : DELAY_LAST)) begin
            w_rep_cnt_nxt[i]  = '0;
            w_rep_next_nxt[i] = 1'b1;
            w_repeat_nxt[i]   = 1'b1;
          end else begin
            w_rep_cnt_nxt[i] = r_rep_cnt[i] + REP_W'(1);
          end
        end else begin
          w_rep_cnt_nxt[i] = r_rep_cnt[i];
        end
      end else begin
        w_rep_cnt_nxt[i]  = '0;
        w_rep_next_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_rep_cnt[i] <= '0;
      end
      r_rep_next <= {NUM_CH{1'b0}};
      r_repeat   <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_rep_cnt[i] <= w_rep_cnt_nxt[i];
      end
      r_rep_next <= w_rep_next_nxt;
      r_repeat   <= w_repeat_nxt;
    end
  end

  assign button_repeat = r_repeat;
`else
  assign button_repeat = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_button_debouncer_array.sv
// Directed bench for button_debouncer_array: 3 channels, 10 kHz clock (10-cycle ms tick), 4 ms debounce.
module tb_button_debouncer_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pins;
  logic [2:0] level, press, release_o, rep;
  logic       any_p;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  button_debouncer_array #(
    .NUM_CH(3), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(4), .ACTIVE_LOW(0),
    .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)
  ) dut (
    .sys_clock(clk), .reset_n(rst_n), .button_in(pins),
    .button_level(level), .button_press(press), .button_release(release_o),
    .button_repeat(rep), .any_press(any_p)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] bad_v;
    bad_v = 13'd0;
    rst_n = 1'b0;
    pins  = 3'b111;
    #2;
    for (int j = 0; j < 20; j++) begin
      if ({level, press, release_o, rep, any_p} !== 13'd0) bad_v = {level, press, release_o, rep, any_p};
      pins = ~pins;
      step();
    end
    tests_run++;
    if (bad_v !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: outputs=%b required=0", bad_v);
    end
    pins = 3'b000;
    step();
    rst_n = 1'b1;
    bad_v = 13'd0;
    for (int j = 0; j < 200; j++) begin
      step();
      if ({level, press, release_o, rep, any_p} !== 13'd0) bad_v = {level, press, release_o, rep, any_p};
    end
    tests_run++;
    if (bad_v !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_release_quiet: outputs=%b required=0", bad_v);
    end
  endtask

  task automatic test_clean_press();
    int pcyc, pcnt, rise, anybad, relcnt;
    logic prev;
    pcyc = -1; pcnt = 0; rise = -1; anybad = 0; relcnt = 0; prev = level[0];
    pins[0] = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (press[0] === 1'b1) begin
        pcnt++;
        if (pcyc < 0) pcyc = n;
      end
      if (level[0] === 1'b1 && prev === 1'b0) rise = n;
      prev = level[0];
      if (any_p !== (|press)) anybad++;
      if (release_o[0] === 1'b1) relcnt++;
    end
    tests_run++;
    if (pcnt != 1) begin
      tests_failed++;
      $display("FAIL press_count: got %0d required 1", pcnt);
    end
    tests_run++;
    if (pcyc < 32 || pcyc > 42) begin
      tests_failed++;
      $display("FAIL press_latency: got %0d cycles required 32..42", pcyc);
    end
    tests_run++;
    if (rise != pcyc) begin
      tests_failed++;
      $display("FAIL level_with_press: level rose at %0d required %0d", rise, pcyc);
    end
    tests_run++;
    if (anybad != 0 || relcnt != 0 || level[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_side: any_press mismatches=%0d releases=%0d level=%b required 0/0/1", anybad, relcnt, level[0]);
    end
  endtask

  task automatic test_release_glitch();
    int bad, rcnt, pcnt;
    bad = 0; rcnt = 0; pcnt = 0;
    for (int j = 1; j <= 100; j++) begin
      pins[0] = (j % 25 == 0) ? 1'b0 : 1'b1;
      step();
      if (level[0] !== 1'b1 || release_o[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL glitch_hold: %0d cycles with level!=1 or release, required 0", bad);
    end
    pins[0] = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (release_o[0] === 1'b1) rcnt++;
      if (press[0] === 1'b1) pcnt++;
    end
    tests_run++;
    if (rcnt != 1 || pcnt != 0 || level[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_release: releases=%0d presses=%0d level=%b required 1/0/0", rcnt, pcnt, level[0]);
    end
  endtask

  task automatic test_bounce();
    int bad, pcyc, pcnt, rcnt;
    bad = 0; pcyc = -1; pcnt = 0; rcnt = 0;
    for (int j = 0; j < 98; j++) begin
      pins[1] = ((j / 7) % 2 == 0) ? 1'b1 : 1'b0;
      step();
      if (level[1] !== 1'b0 || press[1] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bounce_quiet: %0d cycles with level/press on ch1, required 0", bad);
    end
    pins[1] = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (press[1] === 1'b1) begin
        pcnt++;
        if (pcyc < 0) pcyc = n;
      end
    end
    tests_run++;
    if (pcnt != 1 || pcyc < 32 || pcyc > 42) begin
      tests_failed++;
      $display("FAIL bounce_press: count=%0d at=%0d required 1 at 32..42", pcnt, pcyc);
    end
    pins[1] = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (release_o[1] === 1'b1) rcnt++;
    end
    tests_run++;
    if (rcnt != 1 || level[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_release: count=%0d level=%b required 1/0", rcnt, level[1]);
    end
  endtask

  task automatic test_simultaneous();
    int p0, p2, c0, c2, ca, c1;
    p0 = -1; p2 = -2; c0 = 0; c2 = 0; ca = 0; c1 = 0;
    pins = 3'b101;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (press[0] === 1'b1) begin c0++; p0 = n; end
      if (press[2] === 1'b1) begin c2++; p2 = n; end
      if (any_p === 1'b1) ca++;
      if (press[1] !== 1'b0 || level[1] !== 1'b0) c1++;
    end
    tests_run++;
    if (c0 != 1 || c2 != 1 || p0 != p2) begin
      tests_failed++;
      $display("FAIL simul_press: ch0 %0dx@%0d ch2 %0dx@%0d required 1x each same cycle", c0, p0, c2, p2);
    end
    tests_run++;
    if (ca != 1 || c1 != 0) begin
      tests_failed++;
      $display("FAIL simul_any: any_press cycles=%0d ch1 activity=%0d required 1/0", ca, c1);
    end
    pins = 3'b000;
    for (int n = 0; n < 60; n++) step();
    tests_run++;
    if (level !== 3'b000) begin
      tests_failed++;
      $display("FAIL simul_release: level=%b required 000", level);
    end
  endtask

  task automatic wait_press0(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      step();
      if (press[0] === 1'b1) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL press_timeout: no press on ch0 within 60 cycles, required one");
    end
  endtask

`ifdef DEBOUNCER_AUTOREPEAT_EN
  task automatic test_repeat();
    bit ok;
    int first, last, cnt, gapbad, quiet;
    first = -1; last = -1; cnt = 0; gapbad = 0; quiet = 0;
    pins[0] = 1'b1;
    wait_press0(ok);
    tests_run++;
    if (rep[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL repeat_with_press: repeat=%b required 0", rep[0]);
    end
    for (int n = 1; n <= 200; n++) begin
      step();
      if (rep[0] === 1'b1) begin
        cnt++;
        if (first < 0) first = n;
        else if (n - last != 20) gapbad++;
        last = n;
      end
    end
    tests_run++;
    if (first != 50 || cnt != 8 || gapbad != 0) begin
      tests_failed++;
      $display("FAIL repeat_timing: first=%0d count=%0d bad_gaps=%0d required 50/8/0", first, cnt, gapbad);
    end
    pins[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      step();
      if (release_o[0] === 1'b1) ok = 1'b1;
    end
    for (int n = 0; n < 100; n++) begin
      step();
      if (rep[0] !== 1'b0) quiet++;
    end
    tests_run++;
    if (!ok || quiet != 0) begin
      tests_failed++;
      $display("FAIL repeat_after_release: released=%0d repeats=%0d required 1/0", ok, quiet);
    end
  endtask
`else
  task automatic test_repeat();
    bit ok;
    int cnt;
    cnt = 0;
    pins[0] = 1'b1;
    wait_press0(ok);
    for (int n = 1; n <= 200; n++) begin
      step();
      if (rep !== 3'b000) cnt++;
    end
    tests_run++;
    if (cnt != 0) begin
      tests_failed++;
      $display("FAIL repeat_disabled: %0d cycles with repeat set, required 0", cnt);
    end
    pins[0] = 1'b0;
    for (int n = 0; n < 60; n++) step();
  endtask
`endif

  task automatic test_reset_mid_hold();
    bit ok;
    int act;
    act = 0;
    pins[0] = 1'b1;
    wait_press0(ok);
    for (int n = 0; n < 55; n++) step();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({level, press, release_o, rep, any_p} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: outputs=%b required 0", {level, press, release_o, rep, any_p});
    end
    pins = 3'b000;
    for (int n = 0; n < 3; n++) step();
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      step();
      if ({level, press, release_o, rep, any_p} !== 13'd0) act++;
    end
    tests_run++;
    if (act != 0) begin
      tests_failed++;
      $display("FAIL post_reset_quiet: %0d active cycles, required 0", act);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pins  = 3'b000;
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_bounce();
    test_simultaneous();
    test_repeat();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
